cluster_ctrl_unit_v2: RTL and testbench
=======================================

CLUSTER_CTRL_UNIT_V2 -- requirements
Module: cluster_ctrl_unit_v2

Interface
REQ-001 SHALL have parameter NB_CORES, default 8: number of cores; legal range 1..16.
REQ-002 SHALL have parameter NB_ARB_CH, default 2: number of TCDM arbitration channels; legal range 1..8.
REQ-003 SHALL have parameter PER_ID_WIDTH, default 5: width of the request ID.
REQ-004 SHALL have parameter ROM_BOOT_ADDR, default 32'h1A000000: stand-alone boot address for core 0.
REQ-005 SHALL have parameter BOOT_ADDR, default 32'h1C000000: reset value of every boot address.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk_i in 1 (clock); rst_ni in 1 (reset).
REQ-007 SHALL have these control inputs: en_sa_boot_i in 1 (stand-alone boot enable); fetch_en_i in 1 (asynchronous global fetch enable).
REQ-008 SHALL have these slave request ports: req_i in 1; add_i in 32; wen_i in 1 (1=read); wdata_i in 32; be_i in 4; id_i in PER_ID_WIDTH.
REQ-009 SHALL have these slave response ports: gnt_o out 1; r_valid_o out 1; r_rdata_o out 32; r_id_o out PER_ID_WIDTH; r_opc_o out 1 (1=error).
REQ-010 SHALL have these control outputs: eoc_o out 1; event_o out NB_CORES (per-core pulse); cluster_cg_en_o out 1.
REQ-011 SHALL have these configuration outputs: hwpe_sel_o out 1; hwpe_en_o out 1; fregfile_disable_o out 1.
REQ-012 SHALL have these per-core/per-channel outputs: fetch_enable_o out NB_CORES; boot_addr_o out NB_CORES x 32; tcdm_arb_policy_o out NB_ARB_CH.

Function
REQ-013 SHALL decode add_i[7:2] as the word offset; address bits above 7 SHALL be ignored.
REQ-014 SHALL implement this register map:
- 0x00 EOC (RW, bit0).
- 0x04 FETCH_EN (RW, [NB_CORES-1:0]).
- 0x08 FETCH_SET (W1S, reads 0).
- 0x0C FETCH_CLR (W1C, reads 0).
- 0x10 EVENT (WO, reads 0).
- 0x14 CONFIG (RW): bit10 hwpe_sel, bit11 hwpe_en, bit12 fregfile_dis.
- 0x18 CG (RW, bit0).
- 0x1C STATUS (RO): [1:0] boot state, [12:8] NB_CORES, [19:16] NB_ARB_CH.
- 0x40+4i BOOT_ADDR[i] for i<NB_CORES.
- 0x80+4c ARB[c] bit0 for c<NB_ARB_CH.
REQ-015 SHALL apply be_i per byte on RW writes; a byte with be_i=0 is unchanged; W1S/W1C/EVENT SHALL use only bytes with be_i=1.
REQ-016 SHALL treat any offset not listed in REQ-014, including BOOT_ADDR/ARB indices at or above NB_CORES/NB_ARB_CH, as unmapped: writes ignored, read data 0, r_opc_o=1.
REQ-017 SHALL tie gnt_o to 1.
REQ-018 SHALL assert r_valid_o exactly one cycle after every accepted req_i, for both reads and writes.
REQ-019 SHALL return with each response r_id_o = id_i of that request, r_opc_o per REQ-016, and r_rdata_o = register value before the write of that cycle; r_rdata_o=0 for writes.
REQ-020 SHALL return updated data on a read one cycle after a write (no stale read).
REQ-021 SHALL, on a write to EVENT, assert event_o[i] for exactly one cycle (the next cycle) for each wdata bit i set; back-to-back writes SHALL produce back-to-back pulses.
REQ-022 SHALL, on FETCH_SET/FETCH_CLR, set/clear only the fetch bits where wdata=1.
REQ-023 SHALL implement boot FSM states RESET(0), BOOT(1), WAIT_FETCH(2), RUN(3):
- RESET->BOOT unconditionally.
- BOOT->WAIT_FETCH unconditionally; in BOOT with en_sa_boot_i=1, boot_addr[0] SHALL be set to ROM_BOOT_ADDR and fetch_en[0] to 1.
- WAIT_FETCH->RUN when sync fetch_en=1; fetch_en SHALL then be set to all ones.
- RUN is terminal until reset.
REQ-024 SHALL synchronise fetch_en_i through two flops reset to 0; the latency from a fetch_en_i rise to fetch_enable_o=all-ones SHALL be 3 cycles once in WAIT_FETCH.
REQ-025 SHALL give FSM updates priority over a bus write to the same bit in the same cycle.
REQ-026 SHALL drive all outputs directly from flops.

Reset
REQ-027 SHALL, during rst_ni=0, set:
- eoc_o=0, event_o=0, cluster_cg_en_o=0, hwpe_sel_o=1, hwpe_en_o=0, fregfile_disable_o=0.
- fetch_enable_o=0, all boot_addr_o=BOOT_ADDR, tcdm_arb_policy_o=0.
- r_valid_o=0, r_rdata_o=0, r_id_o=0, r_opc_o=0, FSM=RESET.
REQ-028 SHALL, on reset asserted mid-transaction, drop the pending response (r_valid_o=0) and SHALL NOT require it to be reissued.

Verification
REQ-029 SHALL be covered by this scenario: en_sa_boot_i=1 after reset -> boot_addr_o[0]=32'h1A000000, fetch_enable_o=8'h01, STATUS[1:0]=2 by cycle 3.
REQ-030 SHALL be covered by this scenario: fetch_en_i rises in WAIT_FETCH -> fetch_enable_o=8'hFF after 3 cycles, STATUS=3; a FETCH_CLR write in that same cycle loses.
REQ-031 SHALL be covered by this scenario: write FETCH_EN=0x0F, FETCH_SET 0x30, FETCH_CLR 0x01 -> read FETCH_EN=0x3E.
REQ-032 SHALL be covered by this scenario: write BOOT_ADDR[2]=0xDEADBEEF with be=4'b0011 -> read 0x1C00BEEF.
REQ-033 SHALL be covered by this scenario: EVENT writes 0x05 then 0x02 in consecutive cycles -> event_o=0x05 then 0x02 then 0x00.
REQ-034 SHALL be covered by this scenario: read 0x60 with NB_CORES=8, id=5 -> r_valid_o next cycle, r_opc_o=1, r_rdata_o=0, r_id_o=5.

Source files
------------

// File: rtl/cluster_ctrl_unit_v2.sv
// Cluster control unit: a memory-mapped register file holding the per-core fetch enables,
// boot addresses, event pulses and cluster configuration, plus a small boot sequencer.
module cluster_ctrl_unit_v2 #(
    parameter int          NB_CORES      = 8,
    parameter int          NB_ARB_CH     = 2,
    parameter int          PER_ID_WIDTH  = 5,
    parameter logic [31:0] ROM_BOOT_ADDR = 32'h1A000000,
    parameter logic [31:0] BOOT_ADDR     = 32'h1C000000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         en_sa_boot_i,
    input  logic                         fetch_en_i,

    input  logic                         req_i,
    input  logic [31:0]                  add_i,
    input  logic                         wen_i,
    input  logic [31:0]                  wdata_i,
    input  logic [3:0]                   be_i,
    input  logic [PER_ID_WIDTH-1:0]      id_i,

    output logic                         gnt_o,
    output logic                         r_valid_o,
    output logic [31:0]                  r_rdata_o,
    output logic [PER_ID_WIDTH-1:0]      r_id_o,
    output logic                         r_opc_o,

    output logic                         eoc_o,
    output logic [NB_CORES-1:0]          event_o,
    output logic                         cluster_cg_en_o,

    output logic                         hwpe_sel_o,
    output logic                         hwpe_en_o,
    output logic                         fregfile_disable_o,

    output logic [NB_CORES-1:0]          fetch_enable_o,
    output logic [NB_CORES-1:0][31:0]    boot_addr_o,
    output logic [NB_ARB_CH-1:0]         tcdm_arb_policy_o
);

    localparam logic [1:0] S_RESET      = 2'd0;
    localparam logic [1:0] S_BOOT       = 2'd1;
    localparam logic [1:0] S_WAIT_FETCH = 2'd2;
    localparam logic [1:0] S_RUN        = 2'd3;

    localparam logic [5:0] OFF_EOC       = 6'h00;
    localparam logic [5:0] OFF_FETCH_EN  = 6'h01;
    localparam logic [5:0] OFF_FETCH_SET = 6'h02;
    localparam logic [5:0] OFF_FETCH_CLR = 6'h03;
    localparam logic [5:0] OFF_EVENT     = 6'h04;
    localparam logic [5:0] OFF_CONFIG    = 6'h05;
    localparam logic [5:0] OFF_CG        = 6'h06;
    localparam logic [5:0] OFF_STATUS    = 6'h07;
    localparam int         OFF_BOOT_BASE = 16;
    localparam int         OFF_ARB_BASE  = 32;

    logic [1:0]                 state_q, state_d;
    logic [1:0]                 sync_q;
    logic                       eoc_q, eoc_d;
    logic                       cg_q, cg_d;
    logic                       hwpe_sel_q, hwpe_sel_d;
    logic                       hwpe_en_q, hwpe_en_d;
    logic                       freg_dis_q, freg_dis_d;
    logic [NB_CORES-1:0]        fetch_en_q, fetch_en_d;
    logic [NB_CORES-1:0]        event_q, event_d;
    logic [NB_CORES-1:0][31:0]  boot_addr_q, boot_addr_d;
    logic [NB_ARB_CH-1:0]       arb_q, arb_d;

    logic                       r_valid_q, r_valid_d;
    logic [31:0]                r_rdata_q, r_rdata_d;
    logic [PER_ID_WIDTH-1:0]    r_id_q, r_id_d;
    logic                       r_opc_q, r_opc_d;

    logic [5:0]                 off;
    logic                       wr;
    logic [31:0]                bmask;
    logic [NB_CORES-1:0]        fetch_wmask;
    logic [31:0]                rdata_c;
    logic                       hit;
    logic                       unmapped;
    logic                       unused_addr;

    assign off         = add_i[7:2];
    assign wr          = req_i & ~wen_i;
    assign bmask       = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign fetch_wmask = wdata_i[NB_CORES-1:0] & bmask[NB_CORES-1:0];
    assign unused_addr = ^{add_i[31:8], add_i[1:0]};

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        eoc_d       = eoc_q;
        cg_d        = cg_q;
        hwpe_sel_d  = hwpe_sel_q;
        hwpe_en_d   = hwpe_en_q;
        freg_dis_d  = freg_dis_q;
        fetch_en_d  = fetch_en_q;
        boot_addr_d = boot_addr_q;
        arb_d       = arb_q;
        event_d     = '0;
        rdata_c     = '0;
        hit         = 1'b1;

        unique case (off)
            OFF_EOC: begin
                rdata_c = {31'b0, eoc_q};
                if (wr && be_i[0]) eoc_d = wdata_i[0];
            end
            OFF_FETCH_EN: begin
                rdata_c = 32'(fetch_en_q);
                if (wr) fetch_en_d = (fetch_en_q & ~bmask[NB_CORES-1:0]) | fetch_wmask;
            end
            OFF_FETCH_SET: if (wr) fetch_en_d = fetch_en_q | fetch_wmask;
            OFF_FETCH_CLR: if (wr) fetch_en_d = fetch_en_q & ~fetch_wmask;
            OFF_EVENT:     if (wr) event_d = fetch_wmask;
            OFF_CONFIG: begin
                rdata_c = {19'b0, freg_dis_q, hwpe_en_q, hwpe_sel_q, 10'b0};
                if (wr && be_i[1]) begin
                    hwpe_sel_d = wdata_i[10];
                    hwpe_en_d  = wdata_i[11];
                    freg_dis_d = wdata_i[12];
                end
            end
            OFF_CG: begin
                rdata_c = {31'b0, cg_q};
                if (wr && be_i[0]) cg_d = wdata_i[0];
            end
            OFF_STATUS: rdata_c = {12'b0, 4'(NB_ARB_CH), 3'b0, 5'(NB_CORES), 6'b0, state_q};
            default: begin
                hit = 1'b0;
                for (int i = 0; i < NB_CORES; i++) begin
                    if (off == 6'(OFF_BOOT_BASE + i)) begin
                        hit     = 1'b1;
                        rdata_c = boot_addr_q[i];
                        if (wr) boot_addr_d[i] = merge_be(boot_addr_q[i], wdata_i, bmask);
                    end
                end
                for (int c = 0; c < NB_ARB_CH; c++) begin
                    if (off == 6'(OFF_ARB_BASE + c)) begin
                        hit     = 1'b1;
                        rdata_c = {31'b0, arb_q[c]};
                        if (wr && be_i[0]) arb_d[c] = wdata_i[0];
                    end
                end
            end
        endcase

        // The boot sequencer runs after the bus decode so it wins any same-cycle conflict.
        unique case (state_q)
            S_RESET: state_d = S_BOOT;
            S_BOOT: begin
                state_d = S_WAIT_FETCH;
                if (en_sa_boot_i) begin
                    boot_addr_d[0] = ROM_BOOT_ADDR;
                    fetch_en_d[0]  = 1'b1;
                end
            end
            S_WAIT_FETCH: begin
                if (sync_q[1]) begin
                    state_d    = S_RUN;
                    fetch_en_d = '1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign unmapped  = ~hit;
    assign r_valid_d = req_i;
    assign r_id_d    = req_i ? id_i : '0;
    assign r_opc_d   = req_i & unmapped;
    assign r_rdata_d = (req_i && wen_i && !unmapped) ? rdata_c : 32'b0;

    // NOTE: non-blocking assignments only in clocked logic, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RESET;
            sync_q      <= 2'b00;
            eoc_q       <= 1'b0;
            cg_q        <= 1'b0;
            hwpe_sel_q  <= 1'b1;
            hwpe_en_q   <= 1'b0;
            freg_dis_q  <= 1'b0;
            fetch_en_q  <= '0;
            event_q     <= '0;
            // NOTE: the boot address array is a handful of flops, not a RAM, so it is reset like any register.
            boot_addr_q <= {NB_CORES{BOOT_ADDR}};
            arb_q       <= '0;
            r_valid_q   <= 1'b0;
            r_rdata_q   <= '0;
            r_id_q      <= '0;
            r_opc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], fetch_en_i};
            eoc_q       <= eoc_d;
            cg_q        <= cg_d;
            hwpe_sel_q  <= hwpe_sel_d;
            hwpe_en_q   <= hwpe_en_d;
            freg_dis_q  <= freg_dis_d;
            fetch_en_q  <= fetch_en_d;
            event_q     <= event_d;
            boot_addr_q <= boot_addr_d;
            arb_q       <= arb_d;
            r_valid_q   <= r_valid_d;
            r_rdata_q   <= r_rdata_d;
            r_id_q      <= r_id_d;
            r_opc_q     <= r_opc_d;
        end
    end

    assign gnt_o              = 1'b1;
    assign r_valid_o          = r_valid_q;
    assign r_rdata_o          = r_rdata_q;
    assign r_id_o             = r_id_q;
    assign r_opc_o            = r_opc_q;
    assign eoc_o              = eoc_q;
    assign event_o            = event_q;
    assign cluster_cg_en_o    = cg_q;
    assign hwpe_sel_o         = hwpe_sel_q;
    assign hwpe_en_o          = hwpe_en_q;
    assign fregfile_disable_o = freg_dis_q;
    assign fetch_enable_o     = fetch_en_q;
    assign boot_addr_o        = boot_addr_q;
    assign tcdm_arb_policy_o  = arb_q;

endmodule

// File: tb/tb_cluster_ctrl_unit_v2.sv
// Directed bench for cluster_ctrl_unit_v2: boot sequence, register map, byte enables,
// event pulses, unmapped accesses and reset during a transaction.
module tb_cluster_ctrl_unit_v2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  en_sa_boot_i;
    logic                  fetch_en_i;
    logic                  req_i;
    logic [31:0]           add_i;
    logic                  wen_i;
    logic [31:0]           wdata_i;
    logic [3:0]            be_i;
    logic [4:0]            id_i;
    logic                  gnt_o;
    logic                  r_valid_o;
    logic [31:0]           r_rdata_o;
    logic [4:0]            r_id_o;
    logic                  r_opc_o;
    logic                  eoc_o;
    logic [7:0]            event_o;
    logic                  cluster_cg_en_o;
    logic                  hwpe_sel_o;
    logic                  hwpe_en_o;
    logic                  fregfile_disable_o;
    logic [7:0]            fetch_enable_o;
    logic [7:0][31:0]      boot_addr_o;
    logic [1:0]            tcdm_arb_policy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cluster_ctrl_unit_v2 dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_sa_boot_i       (en_sa_boot_i),
        .fetch_en_i         (fetch_en_i),
        .req_i              (req_i),
        .add_i              (add_i),
        .wen_i              (wen_i),
        .wdata_i            (wdata_i),
        .be_i               (be_i),
        .id_i               (id_i),
        .gnt_o              (gnt_o),
        .r_valid_o          (r_valid_o),
        .r_rdata_o          (r_rdata_o),
        .r_id_o             (r_id_o),
        .r_opc_o            (r_opc_o),
        .eoc_o              (eoc_o),
        .event_o            (event_o),
        .cluster_cg_en_o    (cluster_cg_en_o),
        .hwpe_sel_o         (hwpe_sel_o),
        .hwpe_en_o          (hwpe_en_o),
        .fregfile_disable_o (fregfile_disable_o),
        .fetch_enable_o     (fetch_enable_o),
        .boot_addr_o        (boot_addr_o),
        .tcdm_arb_policy_o  (tcdm_arb_policy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus request, driven just after an edge; returns #1 after the capturing edge.
    task automatic bus(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [4:0] id);
        req_i   = 1'b1;
        wen_i   = ~is_wr;
        add_i   = a;
        wdata_i = d;
        be_i    = be;
        id_i    = id;
        @(posedge clk_i); #1;
        req_i   = 1'b0;
        wen_i   = 1'b1;
        add_i   = '0;
        wdata_i = '0;
        be_i    = '0;
        id_i    = '0;
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; en_sa_boot_i = 1'b1; fetch_en_i = 1'b0;
        req_i = 1'b0; wen_i = 1'b1; add_i = '0; wdata_i = '0; be_i = '0; id_i = '0;
        idle(); idle();

        check("rst_fetch",    32'(fetch_enable_o), 32'h0);
        check("rst_boot0",    boot_addr_o[0], 32'h1C000000);
        check("rst_boot7",    boot_addr_o[7], 32'h1C000000);
        check("rst_hwpe_sel", 32'(hwpe_sel_o), 32'h1);
        check("rst_misc",     32'({hwpe_en_o, fregfile_disable_o, eoc_o, cluster_cg_en_o}), 32'h0);
        check("rst_resp",     32'({r_valid_o, r_opc_o, r_id_o}), 32'h0);
        check("rst_event",    32'(event_o), 32'h0);
        check("rst_arb",      32'(tcdm_arb_policy_o), 32'h0);
        check("gnt",          32'(gnt_o), 32'h1);

        rst_ni = 1'b1;
        idle(); idle();
        check("sa_boot0",  boot_addr_o[0], 32'h1A000000);
        check("sa_boot1",  boot_addr_o[1], 32'h1C000000);
        check("sa_fetch",  32'(fetch_enable_o), 32'h01);

        bus(1'b0, 32'h1C, 32'h0, 4'hF, 5'd3);
        check("status_wait",  r_rdata_o, 32'h00020802);
        check("status_valid", 32'({r_valid_o, r_opc_o}), 32'h2);
        check("status_id",    32'(r_id_o), 32'd3);
        idle();
        check("valid_drops",  32'(r_valid_o), 32'h0);

        bus(1'b1, 32'h04, 32'h0F, 4'hF, 5'd1);
        check("wr_rdata0",    r_rdata_o, 32'h0);
        check("wr_valid",     32'(r_valid_o), 32'h1);
        bus(1'b1, 32'h08, 32'h30, 4'hF, 5'd2);
        bus(1'b1, 32'h0C, 32'h01, 4'hF, 5'd3);
        bus(1'b0, 32'h04, 32'h0,  4'hF, 5'd4);
        check("fetch_rd",     r_rdata_o, 32'h3E);
        check("fetch_o",      32'(fetch_enable_o), 32'h3E);
        bus(1'b0, 32'h08, 32'h0,  4'hF, 5'd4);
        check("fetch_set_rd", r_rdata_o, 32'h0);

        bus(1'b1, 32'h48, 32'hDEADBEEF, 4'b0011, 5'd6);
        bus(1'b0, 32'h48, 32'h0, 4'hF, 5'd7);
        check("boot2_rd",     r_rdata_o, 32'h1C00BEEF);
        check("boot2_o",      boot_addr_o[2], 32'h1C00BEEF);

        bus(1'b1, 32'h10, 32'h05, 4'hF, 5'd0);
        check("event_05",     32'(event_o), 32'h05);
        bus(1'b1, 32'h10, 32'h02, 4'hF, 5'd0);
        check("event_02",     32'(event_o), 32'h02);
        idle();
        check("event_00",     32'(event_o), 32'h00);

        bus(1'b0, 32'h60, 32'h0, 4'hF, 5'd5);
        check("unm_valid",    32'(r_valid_o), 32'h1);
        check("unm_opc",      32'(r_opc_o), 32'h1);
        check("unm_rdata",    r_rdata_o, 32'h0);
        check("unm_id",       32'(r_id_o), 32'd5);

        bus(1'b1, 32'hFFFFFF18, 32'h1, 4'hF, 5'd0);
        check("cg_hi_addr",   32'(cluster_cg_en_o), 32'h1);
        bus(1'b1, 32'h14, 32'h1C00, 4'b0010, 5'd0);
        bus(1'b1, 32'h14, 32'h0,    4'b0001, 5'd0);
        check("cfg_o",        32'({fregfile_disable_o, hwpe_en_o, hwpe_sel_o}), 32'h7);
        bus(1'b0, 32'h14, 32'h0, 4'hF, 5'd0);
        check("cfg_rd",       r_rdata_o, 32'h1C00);

        bus(1'b1, 32'h84, 32'h1, 4'hF, 5'd0);
        check("arb1",         32'(tcdm_arb_policy_o), 32'h2);
        bus(1'b1, 32'h88, 32'h1, 4'hF, 5'd0);
        check("arb2_opc",     32'(r_opc_o), 32'h1);
        check("arb2_ignored", 32'(tcdm_arb_policy_o), 32'h2);

        fetch_en_i = 1'b1;
        idle();
        check("sync_1",       32'(fetch_enable_o), 32'h3E);
        idle();
        check("sync_2",       32'(fetch_enable_o), 32'h3E);
        bus(1'b1, 32'h0C, 32'hFF, 4'hF, 5'd0);
        check("fetch_all",    32'(fetch_enable_o), 32'hFF);
        bus(1'b0, 32'h1C, 32'h0, 4'hF, 5'd0);
        check("status_run",   r_rdata_o, 32'h00020803);
        bus(1'b1, 32'h0C, 32'h80, 4'hF, 5'd0);
        check("clr_in_run",   32'(fetch_enable_o), 32'h7F);

        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1C; be_i = 4'hF; id_i = 5'd9;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        check("pre_rst_valid", 32'(r_valid_o), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_drop_valid", 32'(r_valid_o), 32'h0);
        check("rst_drop_fetch", 32'(fetch_enable_o), 32'h0);
        en_sa_boot_i = 1'b0; fetch_en_i = 1'b0;
        idle();
        rst_ni = 1'b1;
        idle(); idle();
        check("nosa_boot0",   boot_addr_o[0], 32'h1C000000);
        check("nosa_fetch",   32'(fetch_enable_o), 32'h0);
        check("nosa_valid",   32'(r_valid_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
